// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Four-digit multiplexed seven-segment display controller.  A 16-bit binary
// value is taken over a valid/ready handshake, saturated to 9999, converted
// to BCD by a bin_to_bcd instance and parked in a one-entry pending buffer.
// The pending value is moved onto the display only at a frame boundary
// (after digit 3 has finished its slot), so a frame never mixes two values.
// A prescaler advances the scanned digit every REFRESH_DIV clock cycles.
//
// Optional feature (compile-time macro):
//   SEG7_LZB_EN - leading-zero blanking; digit k > 0 is dark when nibbles
//                 k..3 of the displayed BCD value are all zero.
//
// Parameters:
//   REFRESH_DIV    - clock cycles each digit stays lit (>= 2)
//   SEG_ACTIVE_LOW - 1: seg_o/an_o active-low (common anode), 0: active-high
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-high reset
//   valid_i   in   binary_i carries a new value
//   binary_i  in   [15:0] unsigned value to display
//   ready_o   out  pending buffer empty; accept on valid_i && ready_o
//   seg_o     out  [6:0] segments {g,f,e,d,c,b,a}
//   an_o      out  [3:0] digit enables, an_o[0] = rightmost digit
//   ovf_o     out  displayed value was saturated
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// bin_to_bcd
//
// Combinational double-dabble converter.  Inputs up to 9999 produce a
// four-digit packed BCD result; larger inputs are not meaningful here since
// the caller saturates before conversion.
//
// Ports:
//   binary_i  in   [15:0] binary value (0..9999)
//   bcd_o     out  [15:0] packed BCD, bcd_o[3:0] = units digit
// ---------------------------------------------------------------------------
module bin_to_bcd (
    input  logic [15:0] binary_i,
    output logic [15:0] bcd_o
);

    logic [31:0] shift;

    // Shift-and-add-3: before each left shift, any BCD digit of 5 or more
    // gets 3 added so that it carries correctly into the next decade.
    always_comb begin
        shift        = 32'h0000_0000;
        shift[15:0]  = binary_i;
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (shift[16 + 4*d +: 4] >= 4'd5) begin
                    shift[16 + 4*d +: 4] = shift[16 + 4*d +: 4] + 4'd3;
                end
            end
            shift = shift << 1;
        end
        bcd_o = shift[31:16];
    end

endmodule

module seg7_scan_ctrl #(
    parameter int REFRESH_DIV    = 100000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [15:0] binary_i,
    output logic        ready_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o,
    output logic        ovf_o
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = (SEG_ACTIVE_LOW != 0) ? 4'hF  : 4'h0;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       dig;
    logic             tick;
    logic             frame_end;
    logic             accept;

    logic [15:0]      sat;
    logic [15:0]      conv_bcd;
    logic [15:0]      pend_bcd;
    logic             pend_ovf;
    logic             pend_full;
    logic [15:0]      disp_bcd;

    logic [3:0]       cur_nibble;
    logic             blank;
    logic [6:0]       seg_hi;
    logic [3:0]       an_hi;

    // Active-high segment pattern for one BCD digit; codes 10..15 never
    // reach the decoder and are shown dark just in case.
    function automatic logic [6:0] decode_digit(input logic [3:0] val);
        case (val)
            4'd0:    decode_digit = 7'h3F;
            4'd1:    decode_digit = 7'h06;
            4'd2:    decode_digit = 7'h5B;
            4'd3:    decode_digit = 7'h4F;
            4'd4:    decode_digit = 7'h66;
            4'd5:    decode_digit = 7'h6D;
            4'd6:    decode_digit = 7'h7D;
            4'd7:    decode_digit = 7'h07;
            4'd8:    decode_digit = 7'h7F;
            4'd9:    decode_digit = 7'h6F;
            default: decode_digit = 7'h00;
        endcase
    endfunction

    assign ready_o   = !pend_full;
    assign accept    = valid_i && !pend_full;
    assign tick      = (div_cnt == DIV_MAX);
    assign frame_end = tick && (dig == 2'd3);
    assign sat       = (binary_i > 16'd9999) ? 16'd9999 : binary_i;

    bin_to_bcd u_bin_to_bcd (
        .binary_i (sat),
        .bcd_o    (conv_bcd)
    );

    // Prescaler and digit index run freely from reset; the digit advances
    // once per REFRESH_DIV cycles and wraps after digit 3.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            dig     <= 2'd0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                dig <= dig + 2'd1;
            end
        end
    end

    // Pending buffer and displayed value.  Accept needs an empty buffer and
    // commit needs a full one, so the two can never happen on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_bcd  <= 16'h0000;
            pend_ovf  <= 1'b0;
            pend_full <= 1'b0;
            disp_bcd  <= 16'h0000;
            ovf_o     <= 1'b0;
        end else begin
            if (accept) begin
                pend_bcd  <= conv_bcd;
                pend_ovf  <= (binary_i > 16'd9999);
                pend_full <= 1'b1;
            end else if (frame_end && pend_full) begin
                disp_bcd  <= pend_bcd;
                ovf_o     <= pend_ovf;
                pend_full <= 1'b0;
            end
        end
    end

    assign cur_nibble = disp_bcd[{dig, 2'b00} +: 4];

    // Blanking decision for the digit currently being scanned.  Digit 0 is
    // never dark so a zero value still shows a single "0".
    always_comb begin
        blank = 1'b0;
`ifdef SEG7_LZB_EN
        case (dig)
            2'd1:    blank = (disp_bcd[15:4]  == 12'h000);
            2'd2:    blank = (disp_bcd[15:8]  == 8'h00);
            2'd3:    blank = (disp_bcd[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`endif
    end

    // Active-high view of the next segment and anode pattern.
    always_comb begin
        seg_hi = 7'h00;
        an_hi  = 4'h0;
        if (!blank) begin
            seg_hi = decode_digit(cur_nibble);
            an_hi  = 4'b0001 << dig;
        end
    end

    // Registered display drive, one cycle behind dig/disp_bcd, with the
    // polarity applied here so both outputs come straight from flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_o <= SEG_OFF;
            an_o  <= AN_OFF;
        end else if (SEG_ACTIVE_LOW != 0) begin
            seg_o <= ~seg_hi;
            an_o  <= ~an_hi;
        end else begin
            seg_o <= seg_hi;
            an_o  <= an_hi;
        end
    end

endmodule
